// File: rtl/motor_pkg.sv
// Shared definitions for the motor sequencing block: timer state codes,
// default timer sizing and the motor option codes used by the motor FSM.
package motor_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam int DEF_PRESCALE = 50000;  // 1 ms per tick at 50 MHz
  localparam int DEF_CNT_W    = 16;

  typedef enum logic [1:0] {
    OPT_NONE      = 2'b00,
    OPT_REVERSE   = 2'b01,
    OPT_BRAKE     = 2'b10,
    OPT_SOFTSTART = 2'b11
  } motor_opt_e;

endpackage

// File: rtl/motor_delay_timer_tick_gen.sv
// Prescaler for the delay timer: counts 0..PRESCALE-1 while enabled and
// flags the wrap cycle as a one-cycle tick.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  // NOTE: sequential state always uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/motor_delay_timer.sv
// Programmable delay timer feeding dly_finished to the motor FSM.
// Define DLY_STICKY_DONE_EN to hold dly_finished until start or cancel.
module motor_delay_timer
  import motor_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cancel,
  input  logic [CNT_W-1:0] dly_len,
  output logic             busy,
  output logic             dly_finished,
  output logic [CNT_W-1:0] remaining
);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             accept, tick, fin_nxt;

  // start is only honoured when no delay is counting and cancel is not asserted
  assign accept = ((state == IDLE) || (state == DONE)) && start && !cancel;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (state == RUN),
    .tick   (tick)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          count_nxt = dly_len;
          state_nxt = (dly_len == '0) ? DONE : RUN;
        end else begin
`ifdef DLY_STICKY_DONE_EN
          if (cancel) state_nxt = IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      RUN: begin
        if (cancel) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (tick) begin
          count_nxt = count - CNT_W'(1);
          if (count == CNT_W'(1)) state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

`ifdef DLY_STICKY_DONE_EN
  assign fin_nxt = (state == DONE) && !start && !cancel;
`else
  assign fin_nxt = (state == DONE);
`endif

  // busy and dly_finished are registered copies of the state, one cycle behind it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      busy         <= 1'b0;
      dly_finished <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      busy         <= (state == RUN);
      dly_finished <= fin_nxt;
    end
  end

  assign remaining = count;

endmodule
